// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, typedefs and port-slice helpers for the integer register file
package regfile_pkg;

    localparam int RF_XLEN = 64;
    localparam int RF_NREG = 32;
    localparam int RF_NRD  = 2;
    localparam int RF_NWR  = 2;
    localparam int RF_NISS = 1;

    function automatic int rf_addr_width(input int nreg);
        return $clog2(nreg);
    endfunction

    localparam int RF_AW    = rf_addr_width(RF_NREG);
    localparam int REG_ZERO = 0;

    typedef logic [RF_XLEN-1:0] xlen_t;
    typedef logic [RF_AW-1:0]   raddr_t;

    // Low bit of port idx inside a flattened bus of w-bit fields.
    function automatic int rf_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy scoreboard for in-flight destinations; RF_BYPASS_EN hides busy on same-cycle retire
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = rf_addr_width(NREG),
    parameter int NRD  = RF_NRD,
    parameter int NWR  = RF_NWR,
    parameter int NISS = RF_NISS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR-1:0]    wclr,
    input  logic [NISS-1:0]   iss_valid,
    input  logic [NISS*AW-1:0] iss_rd,
    input  logic              flush
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        for (int k = 0; k < NISS; k++) begin
            if (iss_valid[k]) set_mask[iss_rd[rf_lo(k, AW) +: AW]] = 1'b1;
        end
        set_mask[REG_ZERO] = 1'b0;
    end

    // Flush first, then retires, then issues: a fresh producer always wins.
    always_comb begin
        busy_next = flush ? '0 : busy;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && wclr[j]) busy_next[waddr[rf_lo(j, AW) +: AW]] = 1'b0;
        end
        busy_next = busy_next | set_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

`ifdef RF_BYPASS_EN
    logic [AW-1:0] ra;
    logic          hit_clr;

    always_comb begin
        rbusy   = '0;
        ra      = '0;
        hit_clr = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra       = raddr[rf_lo(i, AW) +: AW];
            hit_clr  = 1'b0;
            rbusy[i] = (ra == AW'(REG_ZERO)) ? 1'b0 : busy[ra];
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr[rf_lo(j, AW) +: AW] == ra) hit_clr = wclr[j];
            end
            if (hit_clr && !set_mask[ra]) rbusy[i] = 1'b0;
        end
    end
`else
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (raddr[rf_lo(i, AW) +: AW] != AW'(REG_ZERO))
                rbusy[i] = busy[raddr[rf_lo(i, AW) +: AW]];
        end
    end
`endif

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - NRD-read/NWR-write integer register file, x0 = 0; RF_BYPASS_EN adds write-to-read forwarding
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int NRD  = RF_NRD,
    parameter int NWR  = RF_NWR,
    parameter int NISS = RF_NISS,
    parameter int AW   = rf_addr_width(NREG)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NWR-1:0]      wclr,
    input  logic [NISS-1:0]     iss_valid,
    input  logic [NISS*AW-1:0]  iss_rd,
    input  logic                flush
);

    logic [XLEN-1:0] regs [NREG];

    // Ports are visited in ascending order, so the highest colliding port lands last.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr[rf_lo(j, AW) +: AW] != AW'(REG_ZERO))
                    regs[waddr[rf_lo(j, AW) +: AW]] <= wdata[rf_lo(j, XLEN) +: XLEN];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (raddr[rf_lo(i, AW) +: AW] != AW'(REG_ZERO)) begin
                rdata[rf_lo(i, XLEN) +: XLEN] = regs[raddr[rf_lo(i, AW) +: AW]];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && waddr[rf_lo(j, AW) +: AW] == raddr[rf_lo(i, AW) +: AW])
                        rdata[rf_lo(i, XLEN) +: XLEN] = wdata[rf_lo(j, XLEN) +: XLEN];
                end
`endif
            end
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .NWR  (NWR),
        .NISS (NISS)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .raddr     (raddr),
        .rbusy     (rbusy),
        .wen       (wen),
        .waddr     (waddr),
        .wclr      (wclr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - directed and random checks of multiport_regfile against an array model
module tb_multiport_regfile;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NISS = 1;

    logic                clock = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NWR-1:0]      wclr;
    logic [NISS-1:0]     iss_valid;
    logic [NISS*AW-1:0]  iss_rd;
    logic                flush;

    int checks = 0;
    int passes = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    multiport_regfile dut (
        .clock     (clock),
        .reset     (reset),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .wclr      (wclr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush)
    );

    always #5 clock = ~clock;

    task automatic idle();
        reset = 0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
        wclr = '0; iss_valid = '0; iss_rd = '0; flush = 0;
    endtask

    function automatic int ra(input int i);  return int'(raddr[i*AW +: AW]);  endfunction
    function automatic int wa(input int j);  return int'(waddr[j*AW +: AW]);  endfunction

    function automatic bit issued(input int a);
        for (int k = 0; k < NISS; k++)
            if (iss_valid[k] && int'(iss_rd[k*AW +: AW]) == a && a != 0) return 1;
        return 0;
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input int i);
        logic [XLEN-1:0] v;
        if (ra(i) == 0) return '0;
        v = m_regs[ra(i)];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wen[j] && wa(j) == ra(i)) v = wdata[j*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input int i);
        logic b;
        if (ra(i) == 0) return 1'b0;
        b = m_busy[ra(i)];
`ifdef RF_BYPASS_EN
        begin
            int hit = -1;
            for (int j = 0; j < NWR; j++)
                if (wen[j] && wa(j) == ra(i)) hit = j;
            if (hit >= 0 && wclr[hit] && !issued(ra(i))) b = 1'b0;
        end
`endif
        return b;
    endfunction

    // Architectural effect of one clock edge given the inputs currently applied.
    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
            return;
        end
        for (int j = 0; j < NWR; j++)
            if (wen[j] && wa(j) != 0) m_regs[wa(j)] = wdata[j*XLEN +: XLEN];
        if (flush)
            for (int r = 0; r < NREG; r++) m_busy[r] = 0;
        for (int j = 0; j < NWR; j++)
            if (wen[j] && wclr[j]) m_busy[wa(j)] = 0;
        for (int r = 1; r < NREG; r++)
            if (issued(r)) m_busy[r] = 1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ports(input string tag);
        #1;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("%s rdata%0d", tag, i), rdata[i*XLEN +: XLEN], exp_rdata(i));
            chk($sformatf("%s rbusy%0d", tag, i), {63'b0, rbusy[i]}, {63'b0, exp_rbusy(i)});
        end
    endtask

    initial begin
        idle();
        @(negedge clock);

        // 1: reset dominates a concurrent write
        reset = 1; wen = 2'b01; waddr = 10'd5; wdata = 128'hAA;
        tick();
        idle();
        raddr = {5'd0, 5'd5};
        #1;
        chk("reset reg5", rdata[63:0], 64'h0);
        chk("reset rbusy", {62'b0, rbusy}, 64'h0);
        chk_ports("reset");

        // 2: collision, highest port wins
        wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {64'h5678, 64'h1234};
        tick();
        idle();
        raddr = {5'd0, 5'd3};
        #1;
        chk("collision", rdata[63:0], 64'h5678);

        // 3: x0 stays zero and never goes busy
        wen = 2'b01; waddr = 10'd0; wdata = 128'hFFFF; iss_valid = 1; iss_rd = 5'd0;
        tick();
        idle();
        raddr = '0;
        #1;
        chk("x0 data", rdata[63:0], 64'h0);
        chk("x0 busy", {63'b0, rbusy[0]}, 64'h0);

        // 4: issue then retire-and-reissue in the same cycle keeps busy
        iss_valid = 1; iss_rd = 5'd7;
        tick();
        idle();
        raddr = {5'd0, 5'd7};
        #1;
        chk("iss7 busy", {63'b0, rbusy[0]}, 64'h1);
        wen = 2'b01; waddr = 10'd7; wdata = 128'h77; wclr = 2'b01; iss_valid = 1; iss_rd = 5'd7;
        tick();
        idle();
        raddr = {5'd0, 5'd7};
        #1;
        chk("set wins busy", {63'b0, rbusy[0]}, 64'h1);
        chk("set wins data", rdata[63:0], 64'h77);
        wen = 2'b10; waddr = {5'd7, 5'd0}; wdata = {64'h99, 64'h0}; wclr = 2'b10;
        tick();
        idle();
        raddr = {5'd0, 5'd7};
        #1;
        chk("clr7 busy", {63'b0, rbusy[0]}, 64'h0);
        chk("clr7 data", rdata[63:0], 64'h99);

        // 5: flush with a same-cycle issue
        iss_valid = 1; iss_rd = 5'd4;
        tick();
        iss_rd = 5'd9;
        tick();
        idle();
        flush = 1; iss_valid = 1; iss_rd = 5'd9;
        tick();
        idle();
        raddr = {5'd9, 5'd4};
        #1;
        chk("flush r4", {63'b0, rbusy[0]}, 64'h0);
        chk("flush r9", {63'b0, rbusy[1]}, 64'h1);

        // 6: same-cycle read of a register being written
        wen = 2'b01; waddr = 10'd10; wdata = 128'h1111;
        tick();
        idle();
        wen = 2'b01; waddr = 10'd10; wdata = 128'hBEEF; raddr = {5'd0, 5'd10};
        #1;
`ifdef RF_BYPASS_EN
        chk("same-cycle read", rdata[63:0], 64'hBEEF);
`else
        chk("same-cycle read", rdata[63:0], 64'h1111);
`endif
        tick();
        idle();
        raddr = {5'd0, 5'd10};
        #1;
        chk("next-cycle read", rdata[63:0], 64'hBEEF);

        // Random traffic; narrow address window half the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            automatic int hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
            wen       = 2'($urandom);
            wclr      = 2'($urandom);
            iss_valid = 1'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 127) == 0);
            for (int j = 0; j < NWR; j++) begin
                waddr[j*AW +: AW]     = 5'($urandom_range(0, hi));
                wdata[j*XLEN +: XLEN] = {$urandom, $urandom};
            end
            iss_rd = 5'($urandom_range(0, hi));
            for (int i = 0; i < NRD; i++) raddr[i*AW +: AW] = 5'($urandom_range(0, hi));
            chk_ports($sformatf("rand%0d", n));
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
